// File: rtl/demux_pkg.sv
// Purpose: shared constants for the 1-to-4 registered demultiplexer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package demux_pkg;

    localparam int WIDTH = 4;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;
    localparam int CH_D = 3;

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// Purpose: one output channel, a one-entry holding buffer with valid/ready.
// Latency: a loaded word is visible on o_data one cycle after the load edge.
// Backpressure: slot_ready drops only while full and the consumer stalls.
module demux_slot
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             slot_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // A full slot can take a new word in the same cycle its old word drains.
    assign slot_ready = !r_valid || out_ready;
    assign out_data   = r_data;
    assign out_valid  = r_valid;

    // Flush beats load beats drain; data survives drain and flush untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule : demux_slot

// File: rtl/demux1x4.sv
// Purpose: steer one input word by in_sel into one of four buffered channels.
// Latency: 1 cycle from accept edge to out_k/out_valid[k].
// Backpressure: in_ready follows only the addressed slot, so a stalled consumer blocks only its own words.
module demux1x4
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [N-1:0]     out_valid,
    input  logic [N-1:0]     out_ready,
    output logic [7:0]       xfer_cnt
);

    logic [N-1:0]     w_slot_rdy;
    logic [N-1:0]     w_load;
    logic [WIDTH-1:0] w_data [N];
    logic             w_accept;
    logic [7:0]       r_xfer_cnt;

    // in_ready never depends on in_valid, only on flush, in_sel and the slot state.
    assign in_ready = !flush && w_slot_rdy[in_sel];
    assign w_accept = in_valid && in_ready;

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign w_load[k] = w_accept && (in_sel == SEL_W'(k));

        demux_slot u_slot (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .load       (w_load[k]),
            .load_data  (in_data),
            .out_ready  (out_ready[k]),
            .out_data   (w_data[k]),
            .out_valid  (out_valid[k]),
            .slot_ready (w_slot_rdy[k])
        );
    end

    assign out_a    = w_data[CH_A];
    assign out_b    = w_data[CH_B];
    assign out_c    = w_data[CH_C];
    assign out_d    = w_data[CH_D];
    assign xfer_cnt = r_xfer_cnt;

    // Count accepted words; wraps naturally at 8 bits and ignores flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= 8'd0;
        end else if (w_accept) begin
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
    end

endmodule : demux1x4

// File: tb/tb_demux1x4.sv
// Purpose: directed vector table plus hand sequences for reset and counter wrap.
// Latency: checks in_ready before each edge, registered outputs #1 after it.
// Backpressure: exercised through per-channel out_ready patterns in the table.
module tb_demux1x4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] in_data = '0;
    logic [1:0] in_sel = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_a, out_b, out_c, out_d;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'b1111;
    logic [7:0] xfer_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux1x4 dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    typedef struct {
        logic       fl;
        logic [3:0] dat;
        logic [1:0] sel;
        logic       vld;
        logic [3:0] ordy;
        logic       e_rdy;
        logic [3:0] e_a;
        logic [3:0] e_b;
        logic [3:0] e_c;
        logic [3:0] e_d;
        logic [3:0] e_ov;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_regs(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] ov, input logic [7:0] cnt);
        check("out_a", idx, 32'(out_a), 32'(a));
        check("out_b", idx, 32'(out_b), 32'(b));
        check("out_c", idx, 32'(out_c), 32'(c));
        check("out_d", idx, 32'(out_d), 32'(d));
        check("out_valid", idx, 32'(out_valid), 32'(ov));
        check("xfer_cnt", idx, 32'(xfer_cnt), 32'(cnt));
    endtask

    initial begin
        // fl dat sel vld ordy | rdy a b c d ov cnt
        // basic routing, all consumers ready
        vecs.push_back('{0, 4'h3, 2'd0, 1, 4'b1111, 1, 4'h3, 4'h0, 4'h0, 4'h0, 4'b0001, 8'd1});
        vecs.push_back('{0, 4'h5, 2'd1, 1, 4'b1111, 1, 4'h3, 4'h5, 4'h0, 4'h0, 4'b0010, 8'd2});
        vecs.push_back('{0, 4'hA, 2'd2, 1, 4'b1111, 1, 4'h3, 4'h5, 4'hA, 4'h0, 4'b0100, 8'd3});
        vecs.push_back('{0, 4'hF, 2'd3, 1, 4'b1111, 1, 4'h3, 4'h5, 4'hA, 4'hF, 4'b1000, 8'd4});
        vecs.push_back('{0, 4'h0, 2'd3, 0, 4'b1111, 1, 4'h3, 4'h5, 4'hA, 4'hF, 4'b0000, 8'd4});
        // back-pressure on channel c
        vecs.push_back('{0, 4'h7, 2'd2, 1, 4'b1011, 1, 4'h3, 4'h5, 4'h7, 4'hF, 4'b0100, 8'd5});
        vecs.push_back('{0, 4'h9, 2'd2, 1, 4'b1011, 0, 4'h3, 4'h5, 4'h7, 4'hF, 4'b0100, 8'd5});
        vecs.push_back('{0, 4'h1, 2'd1, 1, 4'b1011, 1, 4'h3, 4'h1, 4'h7, 4'hF, 4'b0110, 8'd6});
        vecs.push_back('{0, 4'h9, 2'd2, 1, 4'b1111, 1, 4'h3, 4'h1, 4'h9, 4'hF, 4'b0100, 8'd7});
        vecs.push_back('{0, 4'h0, 2'd2, 0, 4'b1111, 1, 4'h3, 4'h1, 4'h9, 4'hF, 4'b0000, 8'd7});
        // simultaneous drain and load on a, then a stalled hold
        vecs.push_back('{0, 4'h2, 2'd0, 1, 4'b1111, 1, 4'h2, 4'h1, 4'h9, 4'hF, 4'b0001, 8'd8});
        vecs.push_back('{0, 4'h8, 2'd0, 1, 4'b1111, 1, 4'h8, 4'h1, 4'h9, 4'hF, 4'b0001, 8'd9});
        vecs.push_back('{0, 4'hC, 2'd0, 1, 4'b1110, 0, 4'h8, 4'h1, 4'h9, 4'hF, 4'b0001, 8'd9});
        // fill remaining channels with all consumers stalled, then flush
        vecs.push_back('{0, 4'h4, 2'd1, 1, 4'b0000, 1, 4'h8, 4'h4, 4'h9, 4'hF, 4'b0011, 8'd10});
        vecs.push_back('{0, 4'h6, 2'd2, 1, 4'b0000, 1, 4'h8, 4'h4, 4'h6, 4'hF, 4'b0111, 8'd11});
        vecs.push_back('{0, 4'hE, 2'd3, 1, 4'b0000, 1, 4'h8, 4'h4, 4'h6, 4'hE, 4'b1111, 8'd12});
        vecs.push_back('{1, 4'hB, 2'd3, 1, 4'b0000, 0, 4'h8, 4'h4, 4'h6, 4'hE, 4'b0000, 8'd12});
        vecs.push_back('{0, 4'h0, 2'd3, 0, 4'b0000, 1, 4'h8, 4'h4, 4'h6, 4'hE, 4'b0000, 8'd12});
        // load one word ahead of the mid-stream reset
        vecs.push_back('{0, 4'h5, 2'd0, 1, 4'b0000, 1, 4'h5, 4'h4, 4'h6, 4'hE, 4'b0001, 8'd13});

        // reset held for two edges
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", -1, 32'(in_ready), 32'd1);
        check_regs(-1, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 8'd0);

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            flush     = vecs[i].fl;
            in_data   = vecs[i].dat;
            in_sel    = vecs[i].sel;
            in_valid  = vecs[i].vld;
            out_ready = vecs[i].ordy;
            #1;
            check("in_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check_regs(i, vecs[i].e_a, vecs[i].e_b, vecs[i].e_c, vecs[i].e_d, vecs[i].e_ov, vecs[i].e_cnt);
        end

        // mid-stream reset with a pending transfer attempt: nothing counted, all cleared
        @(negedge clk);
        flush     = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 4'h6;
        out_ready = 4'b0000;
        @(posedge clk);
        #1;
        check_regs(100, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 8'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 100, 32'(in_ready), 32'd1);

        // counter wrap: 256 back-to-back accepts into a, consumer always ready
        @(negedge clk);
        out_ready = 4'b1111;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            in_data = 4'(i);
            #1;
            check("wrap_in_ready", 200 + i, 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            if (i == 255) check("wrap_cnt_255", 200 + i, 32'(xfer_cnt), 32'd255);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("wrap_cnt_0", 456, 32'(xfer_cnt), 32'd0);
        check("wrap_out_a", 456, 32'(out_a), 32'h0);
        check("wrap_valid", 456, 32'(out_valid), 32'b0001);
        @(posedge clk);
        #1;
        check("wrap_drain", 457, 32'(out_valid), 32'b0000);
        check("wrap_cnt_hold", 457, 32'(xfer_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_demux1x4
